// File: rtl/half_adder_pkg.sv
// Shared definitions for the half adder bank: the deepest supported output
// pipeline and the one-bit reference function used by the lane cell and
// by anything that needs a golden half-adder result.
package half_adder_pkg;

    localparam int MAX_LATENCY = 4;
    localparam int MAX_WIDTH   = 64;

    // One-bit half adder, packed as {carry, sum}.
    function automatic logic [1:0] ha_ref(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/half_adder_lane.sv
// Single-bit combinational half adder cell. No state, no clock.
module half_adder_lane
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    logic [1:0] result_s;

    assign result_s = ha_ref(a, b);
    assign sum      = result_s[0];
    assign carry    = result_s[1];

endmodule

// File: rtl/half_adder_bank.sv
// Bank of WIDTH independent half adders with an optional LATENCY-deep
// output pipeline. Lanes never exchange carries. With LATENCY = 0 the
// block is pure combinational logic and clk/rst are ignored; otherwise
// every rising edge shifts {sum, carry, valid} one stage with no stall.
// Data stages load unconditionally, so consumers qualify with out_valid.
module half_adder_bank
    import half_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Carry,
    output logic             out_valid
);

    // Reject parameter values the pipeline and lane loop are not built for.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH || LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_param_check
        $error("half_adder_bank: WIDTH must be 1..%0d and LATENCY 0..%0d", MAX_WIDTH, MAX_LATENCY);
    end

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] carry_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .a     (A[i]),
            .b     (B[i]),
            .sum   (sum_s[i]),
            .carry (carry_s[i])
        );
    end

    if (LATENCY == 0) begin : g_comb
        // Clock and reset have no function without pipeline stages.
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ rst;

        assign Sum       = sum_s;
        assign Carry     = carry_s;
        assign out_valid = in_valid;
    end else begin : g_pipe
        logic [WIDTH-1:0] sum_r   [LATENCY];
        logic [WIDTH-1:0] carry_r [LATENCY];
        logic             valid_r [LATENCY];

        // Shift results one stage per edge; reset flushes every in-flight item at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY; i++) begin
                    sum_r[i]   <= '0;
                    carry_r[i] <= '0;
                    valid_r[i] <= 1'b0;
                end
            end else begin
                sum_r[0]   <= sum_s;
                carry_r[0] <= carry_s;
                valid_r[0] <= in_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    sum_r[i]   <= sum_r[i-1];
                    carry_r[i] <= carry_r[i-1];
                    valid_r[i] <= valid_r[i-1];
                end
            end
        end

        assign Sum       = sum_r[LATENCY-1];
        assign Carry     = carry_r[LATENCY-1];
        assign out_valid = valid_r[LATENCY-1];
    end

endmodule

// File: tb/tb_half_adder_bank.sv
// Directed bench for half_adder_bank: truth table at every latency,
// wide combinational vectors, pipeline latency and streaming, and
// asynchronous reset flushing in-flight items.
module tb_half_adder_bank;
    import half_adder_pkg::*;

    logic clk;
    logic rst;

    // WIDTH=1 instances at latency 0..4, sharing inputs
    logic       a1, b1, v1;
    logic [4:0] s1, c1, ov1;

    // WIDTH=8 combinational instance
    logic [7:0] a8, b8, s8, c8;
    logic       v8, ov8;

    // WIDTH=4 instances at latency 2 and 3, sharing inputs
    logic [3:0] a4, b4, s4_2, c4_2, s4_3, c4_3;
    logic       v4, ov4_2, ov4_3;

    int n_cmp  = 0;
    int n_fail = 0;

    half_adder_bank #(.WIDTH(1), .LATENCY(0)) u_w1l0 (.clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Sum(s1[0]), .Carry(c1[0]), .out_valid(ov1[0]));
    half_adder_bank #(.WIDTH(1), .LATENCY(1)) u_w1l1 (.clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Sum(s1[1]), .Carry(c1[1]), .out_valid(ov1[1]));
    half_adder_bank #(.WIDTH(1), .LATENCY(2)) u_w1l2 (.clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Sum(s1[2]), .Carry(c1[2]), .out_valid(ov1[2]));
    half_adder_bank #(.WIDTH(1), .LATENCY(3)) u_w1l3 (.clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Sum(s1[3]), .Carry(c1[3]), .out_valid(ov1[3]));
    half_adder_bank #(.WIDTH(1), .LATENCY(4)) u_w1l4 (.clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Sum(s1[4]), .Carry(c1[4]), .out_valid(ov1[4]));
    half_adder_bank #(.WIDTH(8), .LATENCY(0)) u_w8l0 (.clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Sum(s8), .Carry(c8), .out_valid(ov8));
    half_adder_bank #(.WIDTH(4), .LATENCY(2)) u_w4l2 (.clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Sum(s4_2), .Carry(c4_2), .out_valid(ov4_2));
    half_adder_bank #(.WIDTH(4), .LATENCY(3)) u_w4l3 (.clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Sum(s4_3), .Carry(c4_3), .out_valid(ov4_3));

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden 4-lane result packed as {carry[3:0], sum[3:0]}
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        logic [1:0] l;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            l = ha_ref(a[i], b[i]);
            r[i]     = l[0];
            r[i + 4] = l[1];
        end
        return r;
    endfunction

    initial begin
        logic [3:0] tt_sum;
        logic [3:0] tt_carry;
        logic [7:0] es8, ec8;
        logic [7:0] e4;
        logic [1:0] l;
        logic [1:0] k2;

        tt_sum   = 4'b0110;  // indexed by {A,B}: 00->0 01->1 10->1 11->0
        tt_carry = 4'b1000;  // only 11 carries

        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; v4 = 1'b0;

        // Reset state of every pipelined instance
        #2 rst = 1'b1;
        #2;
        for (int n = 1; n < 5; n++) begin
            chk($sformatf("rst_w1_l%0d", n), {61'd0, ov1[n], s1[n], c1[n]}, 64'd0);
        end
        chk("rst_w4l2", {55'd0, ov4_2, c4_2, s4_2}, 64'd0);
        chk("rst_w4l3", {55'd0, ov4_3, c4_3, s4_3}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 truth table at every latency, plus the sum&carry invariant
        v1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            a1 = k2[1];
            b1 = k2[0];
            #10;
            chk($sformatf("w1l0_sum_%0d", k), 64'(s1[0]), 64'(tt_sum[k]));
            chk($sformatf("w1l0_carry_%0d", k), 64'(c1[0]), 64'(tt_carry[k]));
            repeat (5) @(posedge clk);
            #1;
            for (int n = 0; n < 5; n++) begin
                chk($sformatf("w1_l%0d_sum_%0d", n, k), 64'(s1[n]), 64'(tt_sum[k]));
                chk($sformatf("w1_l%0d_carry_%0d", n, k), 64'(c1[n]), 64'(tt_carry[k]));
                chk($sformatf("w1_l%0d_valid_%0d", n, k), 64'(ov1[n]), 64'd1);
                chk($sformatf("w1_l%0d_inv_%0d", n, k), 64'(s1[n] & c1[n]), 64'd0);
            end
        end
        v1 = 1'b0;

        // WIDTH=8 combinational: directed vector then random vectors
        a8 = 8'hF0; b8 = 8'hAA; v8 = 1'b1;
        #1;
        chk("w8_sum_dir", 64'(s8), 64'h5A);
        chk("w8_carry_dir", 64'(c8), 64'hA0);
        chk("w8_valid_dir", 64'(ov8), 64'd1);
        for (int r = 0; r < 1000; r++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            v8 = 1'($urandom);
            #1;
            for (int i = 0; i < 8; i++) begin
                l = ha_ref(a8[i], b8[i]);
                es8[i] = l[0];
                ec8[i] = l[1];
            end
            chk("w8_rand", {47'd0, ov8, c8, s8}, {47'd0, v8, ec8, es8});
        end

        // WIDTH=4 LATENCY=2: single item, two-edge latency
        @(posedge clk); #1;
        v4 = 1'b1; a4 = 4'hC; b4 = 4'hA;
        @(posedge clk); #1;
        chk("l2_valid_edge1", 64'(ov4_2), 64'd0);
        v4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        @(posedge clk); #1;
        chk("l2_sum_edge2", 64'(s4_2), 64'h6);
        chk("l2_carry_edge2", 64'(c4_2), 64'h8);
        chk("l2_valid_edge2", 64'(ov4_2), 64'd1);
        @(posedge clk); #1;
        chk("l2_valid_edge3", 64'(ov4_2), 64'd0);

        // LATENCY=2 back-to-back stream A=0..15, B=5
        for (int t = 0; t < 18; t++) begin
            if (t < 16) begin
                v4 = 1'b1; a4 = 4'(t); b4 = 4'h5;
            end else begin
                v4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
            end
            @(posedge clk); #1;
            if (t >= 1 && t <= 16) begin
                e4 = ref4(4'(t - 1), 4'h5);
                chk($sformatf("l2_stream_%0d", t - 1), {55'd0, ov4_2, c4_2, s4_2}, {55'd0, 1'b1, e4});
            end else begin
                chk($sformatf("l2_stream_idle_%0d", t), 64'(ov4_2), 64'd0);
            end
        end

        // Mid-stream asynchronous reset with two items in flight
        @(posedge clk); #1;
        v4 = 1'b1; a4 = 4'h3; b4 = 4'h3;
        @(posedge clk); #1;
        a4 = 4'h1; b4 = 4'h2;
        @(posedge clk); #3;
        chk("l2_pre_rst_valid", {55'd0, ov4_2, c4_2, s4_2}, {55'd0, 1'b1, 8'h30});
        rst = 1'b1;
        #1;
        chk("l3_rst_immediate", {55'd0, ov4_3, c4_3, s4_3}, 64'd0);
        chk("l2_rst_immediate", {55'd0, ov4_2, c4_2, s4_2}, 64'd0);
        @(posedge clk); #1;
        chk("l3_rst_hold", {55'd0, ov4_3, c4_3, s4_3}, 64'd0);
        @(negedge clk);
        rst = 1'b0; v4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            chk($sformatf("l3_no_stale_%0d", t), {55'd0, ov4_3, c4_3, s4_3}, 64'd0);
        end

        // LATENCY=3 after reset: first valid item appears three edges later
        v4 = 1'b1; a4 = 4'hF; b4 = 4'h3;
        @(posedge clk); #1;
        v4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        chk("l3_valid_edge1", 64'(ov4_3), 64'd0);
        @(posedge clk); #1;
        chk("l3_valid_edge2", 64'(ov4_3), 64'd0);
        @(posedge clk); #1;
        chk("l3_item_edge3", {55'd0, ov4_3, c4_3, s4_3}, {55'd0, 1'b1, 8'h3C});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/half_adder_bank.md
Name: half_adder_bank

Overview:
- Parameterised bank of WIDTH independent one-bit half adders, each lane computing Sum = A xor B and Carry = A and B.
- Optional pipeline of LATENCY register stages on the outputs, with a valid bit carried alongside.
- Building block for ripple/carry-save adders; the four-bit full adder instantiates WIDTH=1, LATENCY=0 lanes.
- With LATENCY=0 the block is purely combinational and the clock/reset are unused.

Parameters:
- WIDTH, 1, number of independent lanes (1..64).
- LATENCY, 0, output register stages (0..4); 0 = combinational pass-through.

Ports:
- clk  input  1  clock, rising-edge; unused when LATENCY=0.
- rst  input  1  asynchronous, active-high reset; unused when LATENCY=0.
- in_valid  input  1  qualifies A/B for the pipeline.
- A  input  WIDTH  addend bit per lane.
- B  input  WIDTH  addend bit per lane.
- Sum  output  WIDTH  per-lane A xor B.
- Carry  output  WIDTH  per-lane A and B.
- out_valid  output  1  qualifies Sum/Carry.

Behaviour:
- Per lane i, combinational core: s[i] = A[i] ^ B[i], c[i] = A[i] & B[i]. There is no inter-lane carry propagation.
- Truth table per lane (A,B -> Sum,Carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- LATENCY=0:
  - Sum = s, Carry = c, out_valid = in_valid, all combinational.
  - Outputs settle within the same delta/timestep as the inputs change.
- LATENCY=N>0:
  - N-stage shift register of {s, c, in_valid}, clocked on the rising edge of clk.
  - Inputs sampled at edge k appear on the outputs after edge k+N-1 (N cycles of latency).
  - Every edge shifts; there is no stall or backpressure.
  - Data registers load regardless of in_valid; consumers must qualify with out_valid.
- Reset (LATENCY>0):
  - rst=1 asynchronously clears all stages: Sum=0, Carry=0, out_valid=0 immediately, without waiting for a clock edge.
  - Stages hold 0 while rst stays high.
  - After deassertion, the first valid output appears N edges after the first sampled in_valid=1.
  - Reset asserted mid-stream discards all in-flight results; no partial outputs are produced.
- X/Z on A or B propagates through the logic operators; no sanitising.
- Invariant: Sum[i] & Carry[i] is never 1 for any lane.
- Out-of-range parameters (WIDTH<1, LATENCY>4) trigger an elaboration-time $error.

Decomposition:
- Shared package half_adder_pkg holds:
  - MAX_LATENCY=4.
  - A function ha_ref(a, b) returning {carry, sum}, used by both RTL and bench.
- One natural sub-module, half_adder_lane: a single-bit combinational cell, instantiated WIDTH times in a generate loop.
- The pipeline lives in the top as a generate-if on LATENCY with per-stage registers.

Test Plan:
- WIDTH=1, LATENCY=0, sweep {A,B} = 00,01,10,11 with 10 ns settling each -> Sum/Carry = 0/0, 1/0, 1/0, 0/1; all 8 comparisons pass.
- WIDTH=8, LATENCY=0, A=8'hF0, B=8'hAA -> Sum=8'h5A, Carry=8'hA0; repeat 1000 random vectors against ha_ref with zero mismatches.
- WIDTH=4, LATENCY=2:
  - After reset, drive in_valid=1, A=4'hC, B=4'hA at edge 1.
  - Expect Sum=4'h6, Carry=4'h8, out_valid=1 after edge 2, and out_valid=0 before that.
- LATENCY=2 back-to-back: stream A=0..15 with B=4'h5 every cycle -> outputs match ha_ref 2 cycles later, no bubbles.
- Reset mid-stream with LATENCY=3: assert rst between edges with 2 items in flight -> Sum=Carry=0 and out_valid=0 immediately; no stale item emerges after release.
- Exhaustive WIDTH=1 check over all 4 combinations at every latency 0..4 -> Sum&Carry never 1 (assertion).
